// File: rtl/dvs_aer_receiver.sv
// DVS camera AER receiver: synchronizes the 4-phase handshake, decodes
// Y/X address words into timestamped events; includes the timer_us block.
package dvs_ravens_pkg;
  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int AER_BITS          = 10;
  localparam int TIMESTAMP_US_BITS = 32;
  localparam int CLK_PERIOD_NS     = 10;
  localparam int DVS_WIDTH_PXLS    = 320;
  localparam int DVS_HEIGHT_PXLS   = 240;
endpackage

module timer_us
  import dvs_ravens_pkg::*;
#(
  parameter int TS_BITS = TIMESTAMP_US_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [TS_BITS-1:0] time_us
);

  localparam int CYC_PER_US = 1000 / CLK_PERIOD_NS;
  localparam int CW = (CYC_PER_US > 2) ? $clog2(CYC_PER_US) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYC_PER_US - 1);

  logic [CW-1:0]      cyc_q, cyc_d;
  logic [TS_BITS-1:0] time_q, time_d;

  always_comb begin
    cyc_d  = cyc_q + 1'b1;
    time_d = time_q;
    if (cyc_q == CYC_LAST) begin
      cyc_d  = '0;
      time_d = time_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      time_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      time_q <= time_d;
    end
  end

  assign time_us = time_q;

endmodule

module dvs_aer_receiver
  import dvs_ravens_pkg::*;
#(
  parameter int Y_SETUP_NS = 50
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [AER_BITS-1:0]          aer,
  input  logic                         xsel,
  input  logic                         req,
  input  logic [TIMESTAMP_US_BITS-1:0] time_us,
  output logic                         ack,
  output logic [DVS_X_ADDR_BITS-1:0]   event_x,
  output logic [DVS_Y_ADDR_BITS-1:0]   event_y,
  output logic [TIMESTAMP_US_BITS-1:0] event_timestamp,
  output logic                         event_polarity,
  output logic                         new_event
);

  localparam int SETUP_CYC =
    (Y_SETUP_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
  localparam int WAIT_CYC = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    Y_WAIT,
    ACK_X,
    ACK_Y
  } state_e;

  state_e state_q, state_d;

  logic       req_meta_q, req_s_q;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       new_event_q, new_event_d;

  logic [DVS_Y_ADDR_BITS-1:0]   row_y_q, row_y_d;
  logic [DVS_X_ADDR_BITS-1:0]   ex_q, ex_d;
  logic [DVS_Y_ADDR_BITS-1:0]   ey_q, ey_d;
  logic [TIMESTAMP_US_BITS-1:0] ets_q, ets_d;
  logic                         epol_q, epol_d;

  // req is asynchronous; aer/xsel are only looked at once req_s is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= req;
      req_s_q    <= req_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    new_event_d = 1'b0;
    row_y_d     = row_y_q;
    ex_d        = ex_q;
    ey_d        = ey_q;
    ets_d       = ets_q;
    epol_d      = epol_q;
    unique case (state_q)
      IDLE: begin
        if (req_s_q) begin
          if (xsel) begin
            state_d     = ACK_X;
            ack_d       = 1'b1;
            new_event_d = 1'b1;
            ex_d        = aer[DVS_X_ADDR_BITS:1];
            epol_d      = aer[0];
            ey_d        = row_y_q;
            ets_d       = time_us;
          end else begin
            state_d = Y_WAIT;
            cnt_d   = '0;
          end
        end
      end
      Y_WAIT: begin
        // Hold ack off long enough for the sender's Y setup window
        if (cnt_q == WAIT_LAST) begin
          row_y_d = aer[DVS_Y_ADDR_BITS-1:0];
          state_d = ACK_Y;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK_X, ACK_Y: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      new_event_q <= 1'b0;
      row_y_q     <= '0;
      ex_q        <= '0;
      ey_q        <= '0;
      ets_q       <= '0;
      epol_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      new_event_q <= new_event_d;
      row_y_q     <= row_y_d;
      ex_q        <= ex_d;
      ey_q        <= ey_d;
      ets_q       <= ets_d;
      epol_q      <= epol_d;
    end
  end

  assign ack             = ack_q;
  assign new_event       = new_event_q;
  assign event_x         = ex_q;
  assign event_y         = ey_q;
  assign event_timestamp = ets_q;
  assign event_polarity  = epol_q;

endmodule

// File: tb/tb_dvs_aer_receiver.sv
// Directed + randomized bench for dvs_aer_receiver and timer_us.
// Acts as the AER sender and checks every decoded event.
module tb_dvs_aer_receiver;
  import dvs_ravens_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  aer = '0;
  logic        xsel = 1'b0;
  logic        req = 1'b0;
  logic [31:0] time_us;
  logic [3:0]  time_small;
  logic        ack;
  logic [8:0]  event_x;
  logic [8:0]  event_y;
  logic [31:0] event_timestamp;
  logic        event_polarity;
  logic        new_event;

  int total = 0;
  int bad = 0;
  int evt_cnt = 0;

  always #5 clk = ~clk;

  timer_us u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .time_us (time_us)
  );

  timer_us #(.TS_BITS(4)) u_tmr4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .time_us (time_small)
  );

  dvs_aer_receiver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .aer             (aer),
    .xsel            (xsel),
    .req             (req),
    .time_us         (time_us),
    .ack             (ack),
    .event_x         (event_x),
    .event_y         (event_y),
    .event_timestamp (event_timestamp),
    .event_polarity  (event_polarity),
    .new_event       (new_event)
  );

  always @(negedge clk) if (new_event) evt_cnt++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ts_ok(input logic [31:0] ts, input longint t0);
    longint d;
    d = longint'(ts) - t0 / 1000;
    return (d >= -1) && (d <= 1);
  endfunction

  task automatic send(input logic xs, input logic [9:0] w, input int dly,
                      output longint t0, output longint t_ack,
                      output int fall_cyc);
    int n;
    aer = w;
    xsel = xs;
    #(dly);
    t0 = $time;
    req = 1'b1;
    n = 0;
    while (!ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ack) chk("ack_timeout", 1'b0, 1'b1);
    t_ack = $time - 5;
    #($urandom_range(0, 20));
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    while (ack && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    if (ack) chk("ack_fall_timeout", 1'b0, 1'b1);
    fall_cyc = n;
  endtask

  task automatic send_x(input logic [8:0] x, input logic pol,
                        input logic [8:0] y, input string tag);
    longint t0, ta;
    int fc, c0;
    c0 = evt_cnt;
    send(1'b1, {x, pol}, $urandom_range(0, 20), t0, ta, fc);
    chk({tag, "_cnt"}, evt_cnt - c0, 1);
    chk({tag, "_x"}, event_x, x);
    chk({tag, "_y"}, event_y, y);
    chk({tag, "_pol"}, event_polarity, pol);
    chk({tag, "_ts"}, ts_ok(event_timestamp, t0), 1'b1);
  endtask

  initial begin
    longint t0, ta;
    int fc, c0, n;
    logic [8:0] ry, rx;
    logic rp;

    // reset with req held high
    #10 rst_n = 1'b0;
    req = 1'b1;
    #8;
    chk("rst_ack", ack, 1'b0);
    chk("rst_new", new_event, 1'b0);
    chk("rst_x", event_x, 0);
    chk("rst_y", event_y, 0);
    chk("rst_ts", event_timestamp, 0);
    chk("rst_pol", event_polarity, 1'b0);
    #2 rst_n = 1'b1;
    req = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("rst_no_ack", ack, 1'b0);

    send_x(9'd7, 1'b1, 9'd0, "x_noy");

    // Y word 0x0A5
    c0 = evt_cnt;
    send(1'b0, 10'h0A5, 3, t0, ta, fc);
    chk("y_setup", (ta - t0) >= 50, 1'b1);
    chk("y_no_evt", evt_cnt - c0, 0);
    chk("y_fall", (fc >= 1) && (fc <= 3), 1'b1);

    send_x(9'h12C, 1'b1, 9'h0A5, "x1");
    send_x(9'h003, 1'b0, 9'h0A5, "x2");

    c0 = evt_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_x", event_x, 9'h003);
    chk("hold_y", event_y, 9'h0A5);
    chk("hold_pol", event_polarity, 1'b0);
    chk("hold_new", new_event, 1'b0);
    chk("hold_cnt", evt_cnt - c0, 0);

    // Y word with aer[9] set: bit 9 must be ignored
    send(1'b0, 10'h3FF, 0, t0, ta, fc);
    send_x(9'h1FF, 1'b0, 9'h1FF, "x_full");

    for (int i = 0; i < 30; i++) begin
      ry = 9'($urandom_range(0, DVS_HEIGHT_PXLS - 1));
      send(1'b0, {1'b0, ry}, $urandom_range(0, 20), t0, ta, fc);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        rx = 9'($urandom_range(0, DVS_WIDTH_PXLS - 1));
        rp = 1'($urandom_range(0, 1));
        send_x(rx, rp, ry, "rnd");
      end
      if ($urandom_range(0, 5) == 0) #($urandom_range(1000, 1100));
    end

    // reset in the middle of a Y handshake
    aer = 10'h055;
    xsel = 1'b0;
    req = 1'b1;
    n = 0;
    while (!ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("mid_ack_up", ack, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 1'b0);
    chk("mid_rst_x", event_x, 0);
    chk("mid_rst_y", event_y, 0);
    req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // timer_us counting and wrap
    repeat (99) @(posedge clk);
    #1 chk("tmr_99", time_us, 0);
    @(posedge clk);
    #1 chk("tmr_100", time_us, 1);
    repeat (1400) @(posedge clk);
    #1 chk("tmr4_15", time_small, 4'd15);
    repeat (100) @(posedge clk);
    #1;
    chk("tmr4_wrap", time_small, 4'd0);
    chk("tmr_1600", time_us, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
